convolution_coprocessor_input_loader: RTL and testbench

CONVOLUTION_COPROCESSOR_INPUT_LOADER -- requirements
Module: convolution_coprocessor_input_loader

---
 rtl/convolution_coprocessor_input_loader_if.sv | 27 ++
 rtl/convolution_coprocessor_input_loader.sv | 129 ++++++++++++
 tb/tb_convolution_coprocessor_input_loader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/convolution_coprocessor_input_loader_if.sv
// Streaming-input, memY read port and coprocessor handshake bundle for the input loader.
interface convolution_coprocessor_input_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;
    logic [ADDR_WIDTH-1:0] memY_addr;
    logic [DATA_WIDTH-1:0] dataY;
    logic [ADDR_WIDTH-1:0] sizeY;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  overflow;

    modport slave (
        input  s_data, s_valid, s_last, memY_addr, busy, done,
        output s_ready, dataY, sizeY, start, overflow
    );

    modport master (
        output s_data, s_valid, s_last, memY_addr, busy, done,
        input  s_ready, dataY, sizeY, start, overflow
    );
endinterface

// File: rtl/convolution_coprocessor_input_loader.sv
// Buffers one streamed frame into memY, then launches the coprocessor and waits for done.
// Define LOADER_OVF_DRAIN_EN to drain over-long frames (sticky overflow) instead of splitting them.
module convolution_coprocessor_input_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic clk,
    input  logic rst,
    convolution_coprocessor_input_loader_if.slave bus
);
    // Index of the last storable beat (2**ADDR_WIDTH-2); address 2**ADDR_WIDTH-1 is never written.
    localparam logic [ADDR_WIDTH-1:0] LIMIT_IDX = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [ADDR_WIDTH-1:0] ONE       = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LAUNCH,
        WAIT_BUSY,
        RUN
`ifdef LOADER_OVF_DRAIN_EN
        , DRAIN
`endif
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [ADDR_WIDTH-1:0] size_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  ready;
    logic                  start_int;
    logic                  accept;
    logic                  ram_we;
    logic                  at_limit;

    logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];

    assign at_limit = (wr_cnt == LIMIT_IDX);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, LOAD: begin
                if (accept) begin
                    if (bus.s_last)
                        state_nxt = LAUNCH;
                    else if (at_limit)
`ifdef LOADER_OVF_DRAIN_EN
                        state_nxt = DRAIN;
`else
                        state_nxt = LAUNCH;
`endif
                    else
                        state_nxt = LOAD;
                end
            end
`ifdef LOADER_OVF_DRAIN_EN
            DRAIN:     if (accept && bus.s_last) state_nxt = LAUNCH;
`endif
            LAUNCH:    state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (bus.busy) state_nxt = RUN;
            RUN:       if (bus.done) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Reset masks ready and start combinationally so neither is seen during the reset cycle.
    always_comb begin
        ready     = 1'b0;
        start_int = 1'b0;
        case (state)
            IDLE, LOAD: ready     = !rst;
`ifdef LOADER_OVF_DRAIN_EN
            DRAIN:      ready     = !rst;
`endif
            LAUNCH:     start_int = !rst;
            default:    ;
        endcase
        accept = bus.s_valid && ready;
        ram_we = accept && (state == IDLE || state == LOAD);
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[wr_cnt] <= bus.s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
            size_q <= '0;
            data_q <= '0;
        end else begin
            data_q <= ram[bus.memY_addr];
            if (state == RUN && bus.done)
                wr_cnt <= '0;
            else if (ram_we)
                wr_cnt <= wr_cnt + ONE;
            // Drained beats are not counted, so the stored length is the counter itself there.
            if (state_nxt == LAUNCH && state != LAUNCH)
                size_q <= ram_we ? wr_cnt + ONE : wr_cnt;
        end
    end

`ifdef LOADER_OVF_DRAIN_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (ram_we && at_limit && !bus.s_last)
            ovf_q <= 1'b1;
    end

    assign bus.overflow = ovf_q;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.s_ready = ready;
    assign bus.start   = start_int;
    assign bus.sizeY   = size_q;
    assign bus.dataY   = data_q;
endmodule

// File: tb/tb_convolution_coprocessor_input_loader.sv
// Self-checking bench for the input loader: table vectors, corner sequences and random frames vs. a frame model.
module tb_convolution_coprocessor_input_loader;
    localparam int DW   = 8;
    localparam int AW   = 5;
    localparam int MAXF = 31;
`ifdef LOADER_OVF_DRAIN_EN
    localparam bit DRAIN_EN = 1'b1;
`else
    localparam bit DRAIN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    convolution_coprocessor_input_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    convolution_coprocessor_input_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;

    logic [DW-1:0] beats [64];
    logic [DW-1:0] model_ram [32];
    bit            model_known [32];
    bit            model_ovf;

    typedef struct {
        int            len;
        logic [DW-1:0] base;
        int            rd_addr;
        int            exp_size;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t tbl [4];

    always @(posedge clk) begin
        if (bus.start === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Spec-level model: a frame stores its first min(n,31) beats from address 0.
    task automatic model_frame(input int n, output int size);
        size = (n > MAXF) ? MAXF : n;
        for (int i = 0; i < size; i++) begin
            model_ram[i]   = beats[i];
            model_known[i] = 1'b1;
        end
        if (n > MAXF && DRAIN_EN) model_ovf = 1'b1;
    endtask

    task automatic send_frame(input int n, input bit gaps, input bit last_flag);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.s_valid = 1'b0;
                step();
            end
            bus.s_valid = 1'b1;
            bus.s_data  = beats[i];
            bus.s_last  = last_flag && (i == n - 1);
            while (!bus.s_ready && w < 200) begin
                step();
                w++;
            end
            if (w >= 200) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: beat %0d not accepted within 200 cycles", i);
                bus.s_valid = 1'b0;
                return;
            end
            step();
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic run_coproc(input int bdly, input int run_len, input bit hold);
        int s0 = start_cnt;
        for (int k = 0; k < bdly; k++) begin
            chk("ready_wait_busy", bus.s_ready, 0);
            step();
        end
        bus.busy = 1'b1;
        step();
        if (hold) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'hAA;
            bus.s_last  = 1'b1;
        end
        for (int k = 0; k < run_len; k++) begin
            chk("ready_in_run", bus.s_ready, 0);
            step();
        end
        bus.done = 1'b1;
        step();
        bus.done    = 1'b0;
        bus.busy    = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        chk("ready_after_done", bus.s_ready, 1);
        step();
        chk("no_start_from_run", start_cnt - s0, 0);
    endtask

    task automatic do_frame(input int n, input bit gaps, input bit last_flag, input int exp_size,
                            input bit hold, input int run_len, input int bdly);
        int s0 = start_cnt;
        send_frame(n, gaps, last_flag);
        chk("start_on_launch", bus.start, 1);
        chk("ready_in_launch", bus.s_ready, 0);
        chk("sizeY", bus.sizeY, exp_size);
        step();
        chk("start_one_cycle", bus.start, 0);
        chk("start_count", start_cnt - s0, 1);
        run_coproc(bdly, run_len, hold);
        chk("sizeY_held", bus.sizeY, exp_size);
    endtask

    task automatic rd(input int addr, input logic [DW-1:0] exp, input string name);
        bus.memY_addr = addr[AW-1:0];
        step();
        chk(name, bus.dataY, exp);
    endtask

    task automatic check_ram(input string name);
        for (int a = 0; a < 32; a++)
            if (model_known[a]) rd(a, model_ram[a], name);
    endtask

    initial begin
        int sz;
        int s0;

        tbl[0] = '{len: 5,  base: 8'h01, rd_addr: 2,  exp_size: 5,  exp_rd: 8'h03};
        tbl[1] = '{len: 1,  base: 8'h7F, rd_addr: 0,  exp_size: 1,  exp_rd: 8'h7F};
        tbl[2] = '{len: 31, base: 8'h40, rd_addr: 30, exp_size: 31, exp_rd: 8'h5E};
        tbl[3] = '{len: 12, base: 8'hF0, rd_addr: 11, exp_size: 12, exp_rd: 8'hFB};

        for (int a = 0; a < 32; a++) model_known[a] = 1'b0;
        model_ovf     = 1'b0;
        rst           = 1'b1;
        bus.s_data    = '0;
        bus.s_valid   = 1'b0;
        bus.s_last    = 1'b0;
        bus.memY_addr = '0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;

        step();
        step();
        chk("rst_ready", bus.s_ready, 0);
        chk("rst_sizeY", bus.sizeY, 0);
        chk("rst_start", bus.start, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_dataY", bus.dataY, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", bus.s_ready, 1);

        // Table vectors; the first one also holds s_valid through a 20-cycle RUN.
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < tbl[v].len; i++) beats[i] = tbl[v].base + DW'(i);
            model_frame(tbl[v].len, sz);
            do_frame(tbl[v].len, 1'b0, 1'b1, tbl[v].exp_size, v == 0, (v == 0) ? 20 : 3, v);
            rd(tbl[v].rd_addr, tbl[v].exp_rd, "table_read");
            chk("table_overflow", bus.overflow, 0);
        end

        // Over-long frame of 35 beats.
        for (int i = 0; i < 35; i++) beats[i] = DW'(i + 1);
`ifdef LOADER_OVF_DRAIN_EN
        model_frame(35, sz);
        do_frame(35, 1'b0, 1'b1, 31, 1'b0, 4, 1);
        chk("drain_overflow", bus.overflow, 1);
        rd(30, 8'h1F, "drain_ram30");
`else
        model_frame(31, sz);
        do_frame(31, 1'b0, 1'b0, 31, 1'b0, 4, 1);
        chk("split_overflow", bus.overflow, 0);
        rd(30, 8'h1F, "split_ram30");
        for (int i = 0; i < 4; i++) beats[i] = DW'(32 + i);
        model_frame(4, sz);
        do_frame(4, 1'b0, 1'b1, 4, 1'b0, 2, 0);
        rd(0, 8'h20, "split_second_ram0");
        rd(4, 8'h05, "split_stale_ram4");
`endif

        // Reset in the middle of LOAD abandons the frame.
        beats[0] = 8'hA1;
        beats[1] = 8'hA2;
        beats[2] = 8'hA3;
        s0 = start_cnt;
        send_frame(3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            model_ram[i]   = beats[i];
            model_known[i] = 1'b1;
        end
        rst = 1'b1;
        #1;
        chk("midrst_ready", bus.s_ready, 0);
        step();
        chk("midrst_sizeY", bus.sizeY, 0);
        chk("midrst_overflow", bus.overflow, 0);
        chk("midrst_dataY", bus.dataY, 0);
        rst = 1'b0;
        model_ovf = 1'b0;
        #1;
        chk("midrst_ready_after", bus.s_ready, 1);
        step();
        chk("midrst_no_start", start_cnt - s0, 0);
        beats[0] = 8'h55;
        beats[1] = 8'h66;
        model_frame(2, sz);
        do_frame(2, 1'b0, 1'b1, 2, 1'b0, 2, 0);
        rd(0, 8'h55, "midrst_ram0");
        rd(2, 8'hA3, "midrst_stale_ram2");
        check_ram("ram_after_reset");

        // Random frames with stray busy/done in IDLE, valid gaps and random coprocessor timing.
        for (int f = 0; f < 10; f++) begin
            int n;
            n = DRAIN_EN ? int'($urandom_range(1, 40)) : int'($urandom_range(1, MAXF));
            for (int i = 0; i < n; i++) beats[i] = DW'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                s0 = start_cnt;
                bus.busy = 1'b1;
                bus.done = 1'b1;
                step();
                bus.busy = 1'b0;
                bus.done = 1'b0;
                chk("idle_ignores_done", bus.s_ready, 1);
                step();
                chk("idle_no_start", start_cnt - s0, 0);
            end
            model_frame(n, sz);
            do_frame(n, 1'b1, 1'b1, sz, $urandom_range(0, 1) == 1,
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
            chk("rand_overflow", bus.overflow, model_ovf);
            check_ram("rand_ram");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
